fir_capture: RTL and testbench

Hardware sink for the 16-bit signed output stream of the FIR filters (`Fir3Tap` and its approximate variants). It discards the filter's warm-up samples, stores a programmed number of output samples in an internal buffer, then drains them to a host over a valid/ready handshake with a last marker. It sits on the filter's `y` output and replaces file-based capture for on-chip ECG runs.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/capture_ram.sv | 36 +++
 rtl/fir_capture.sv | 169 ++++++++++++++++
 tb/tb_fir_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types for the FIR output capture path: sample width,
//                sample type and the capture state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_SKIP  = 2'd1,
        CAP_FILL  = 2'd2,
        CAP_DRAIN = 2'd3
    } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ram
//  Description : DEPTH-entry sample buffer, one synchronous write port and one
//                asynchronous read port. The array has no reset so it can map
//                onto distributed RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ram
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming sample bit-exact at the write pointer
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fir_capture.sv
`default_nettype none
// ============================================================================
//  Module      : fir_capture
//  Description : Sink for the FIR filter output stream. Discards SKIP warm-up
//                samples, buffers a programmed number of samples, then drains
//                them over a valid/ready handshake with a last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_capture
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DEPTH  = 256,
    parameter int SKIP   = 2,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         capture_len,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int                AW      = $clog2(DEPTH);
    localparam int                SKW     = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0]  ONE_L   = LEN_W'(1);
    localparam logic [SKW-1:0]    SKIP_L  = SKW'(SKIP);

    cap_state_e                state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [SKW-1:0]            skip_q, skip_d;
    logic [LEN_W-1:0]          wr_q, wr_d;
    logic [LEN_W-1:0]          rd_q, rd_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      done_q, done_d;

    logic                      w_ram_we;
    logic [AW-1:0]             w_ram_raddr;
    logic [DATA_W-1:0]         w_ram_rdata;
    logic [LEN_W-1:0]          w_rd_next;
    logic [LEN_W-1:0]          w_len_clamped;

    assign w_ram_we      = (state_q == CAP_FILL) && in_valid;
    assign w_rd_next     = rd_q + ONE_L;
    assign w_len_clamped = (capture_len > DEPTH_L) ? DEPTH_L : capture_len;
    // Before the first sample is presented rd is 0; afterwards the register
    // is reloaded with the entry following the one being handed over.
    assign w_ram_raddr   = out_valid_q ? (rd_q[AW-1:0] + AW'(1)) : rd_q[AW-1:0];

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (w_ram_raddr),
        .rdata_o (w_ram_rdata)
    );

    // State, counters and output register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CAP_IDLE;
            len_q       <= '0;
            skip_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            skip_q      <= skip_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter and output-register logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        skip_d      = skip_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            CAP_IDLE: begin
                if (start) begin
                    len_d  = w_len_clamped;
                    skip_d = '0;
                    wr_d   = '0;
                    rd_d   = '0;
                    if (w_len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = (SKIP == 0) ? CAP_FILL : CAP_SKIP;
                    end
                end
            end
            CAP_SKIP: begin
                if (in_valid) begin
                    skip_d = skip_q + SKW'(1);
                    if ((skip_q + SKW'(1)) == SKIP_L) begin
                        state_d = CAP_FILL;
                    end
                end
            end
            CAP_FILL: begin
                if (in_valid) begin
                    wr_d = wr_q + ONE_L;
                    if ((wr_q + ONE_L) == len_q) begin
                        state_d = CAP_DRAIN;
                    end
                end
            end
            CAP_DRAIN: begin
                if (!out_valid_q) begin
                    // First cycle in DRAIN: load mem[0]
                    out_valid_d = 1'b1;
                    out_data_d  = w_ram_rdata;
                    out_last_d  = (len_q == ONE_L);
                end else if (out_ready) begin
                    rd_d = w_rd_next;
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = CAP_IDLE;
                    end else begin
                        out_data_d = w_ram_rdata;
                        out_last_d = (w_rd_next == (len_q - ONE_L));
                    end
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign busy      = (state_q != CAP_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_capture
//  Description : Directed bench for fir_capture with an expected-output queue
//                and an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_capture;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         capture_len;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    typedef struct packed {
        logic signed [15:0] d;
        logic               l;
    } exp_t;

    exp_t q[$];

    int n_cmp  = 0;
    int n_err  = 0;
    int n_hs   = 0;
    int n_done = 0;

    logic               hold_v = 1'b0;
    logic signed [15:0] hold_d;
    logic               hold_l;

    always #5 clk = ~clk;

    fir_capture #(
        .DEPTH (256),
        .SKIP  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .capture_len (capture_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: pops the queue on every handshake, checks hold stability
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (hold_v && out_valid) begin
                chk("hold_data", {16'd0, out_data}, {16'd0, hold_d});
                chk("hold_last", {31'd0, out_last}, {31'd0, hold_l});
            end
            if (done) n_done++;
            if (out_valid && out_ready) begin
                n_hs++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0d required none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.l});
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        capture_len = len[8:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic signed [15:0] v, input logic l);
        q.push_back(exp_t'{d: v, l: l});
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            tick();
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles required done", bound);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        int hs0;
        int dn0;
        logic [5:0] pat;
        logic signed [15:0] v;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; capture_len = '0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        rst = 1'b0;
        tick();

        // Basic capture, consecutive drain
        do_start(4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        expect_out(16'sd10, 1'b0);
        expect_out(-16'sd20, 1'b0);
        expect_out(16'sd30, 1'b0);
        expect_out(16'sd32767, 1'b1);
        send(-16'sd3); send(-16'sd2); send(16'sd10);
        send(-16'sd20); send(16'sd30); send(16'sd32767);
        wait_done(20, c);
        chk("t1_latency", c, 32'd5);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_q_empty", q.size(), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        hs0 = n_hs;
        do_start(3);
        send(16'sd100); send(16'sd200);
        expect_out(16'sd5, 1'b0);
        expect_out(-16'sd6, 1'b0);
        expect_out(16'sd7, 1'b1);
        send(16'sd5); send(-16'sd6); send(16'sd7);
        pat = 6'b110100;
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i];
            tick();
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_handshakes", n_hs - hs0, 32'd3);
        out_ready = 1'b1;
        tick();

        // Gapped input, in_valid ignored during DRAIN
        out_ready = 1'b0;
        hs0 = n_hs;
        do_start(5);
        expect_out(16'sd11, 1'b0);
        expect_out(-16'sd12, 1'b0);
        expect_out(16'sd13, 1'b0);
        expect_out(-16'sd14, 1'b0);
        expect_out(16'sd15, 1'b1);
        send(16'sd1000); tick(); tick();
        send(16'sd1001); tick(); tick();
        send(16'sd11);   tick(); tick();
        send(-16'sd12);  tick(); tick();
        send(16'sd13);   tick(); tick();
        send(-16'sd14);  tick(); tick();
        send(16'sd15);   tick(); tick();
        repeat (3) begin
            send(-16'sd999);
            tick();
        end
        out_ready = 1'b1;
        wait_done(20, c);
        chk("t3_handshakes", n_hs - hs0, 32'd5);
        tick();

        // Zero-length capture
        dn0 = n_done;
        do_start(0);
        chk("t4_done_now", {31'd0, done}, 32'd1);
        chk("t4_not_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t4_done_low", {31'd0, done}, 32'd0);
        repeat (3) tick();
        chk("t4_no_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_done_count", n_done - dn0, 32'd1);

        // Oversized request clamps to DEPTH
        hs0 = n_hs;
        do_start(300);
        send(16'sd1); send(16'sd2);
        for (int i = 0; i < 256; i++) begin
            v = 16'(i * 129 - 16000);
            expect_out(v, (i == 255));
            send(v);
        end
        wait_done(400, c);
        chk("t5_latency", c, 32'd257);
        chk("t5_handshakes", n_hs - hs0, 32'd256);
        tick();

        // Reset in the middle of FILL
        do_start(4);
        send(16'sd1); send(16'sd2);
        send(16'sd500); send(16'sd600);
        rst = 1'b1;
        tick();
        chk("t6_rst_busy",      {31'd0, busy},      32'd0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_out_last",  {31'd0, out_last},  32'd0);
        chk("t6_rst_done",      {31'd0, done},      32'd0);
        chk("t6_rst_out_data",  {16'd0, out_data},  32'd0);
        rst = 1'b0;
        do_start(2);
        expect_out(16'sd77, 1'b0);
        expect_out(-16'sd78, 1'b1);
        send(16'sd3); send(16'sd4);
        send(16'sd77); send(-16'sd78);
        wait_done(20, c);
        tick();

        // Start during DRAIN ignored; start with done honoured
        out_ready = 1'b0;
        do_start(2);
        send(16'sd1); send(16'sd2);
        expect_out(16'sd21, 1'b0);
        expect_out(16'sd22, 1'b1);
        send(16'sd21); send(16'sd22);
        tick();
        do_start(1);
        chk("t7_busy_drain", {31'd0, busy}, 32'd1);
        chk("t7_valid_drain", {31'd0, out_valid}, 32'd1);
        chk("t7_data_drain", {16'd0, out_data}, {16'd0, 16'sd21});
        out_ready = 1'b1;
        wait_done(10, c);
        chk("t7_idle_at_done", {31'd0, busy}, 32'd0);
        do_start(1);
        chk("t7_busy_restart", {31'd0, busy}, 32'd1);
        send(16'sd5); send(16'sd6);
        expect_out(-16'sd32768, 1'b1);
        send(-16'sd32768);
        wait_done(10, c);
        tick();
        tick();

        chk("final_q_empty", q.size(), 32'd0);
        chk("final_done_count", n_done, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
